// File: rtl/vga_timing_ctrl_pkg.sv
// Shared raster timing constants and types for the 640x480@60 display path.
// Graphics and the timing controller both take their defaults from here.
package vga_timing_ctrl_pkg;

  localparam int CNT_W   = 11;
  localparam int COLOR_W = 4;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic DEF_HS_POL = 1'b0;
  localparam logic DEF_VS_POL = 1'b0;

  // Coordinate-to-colour latency of the graphics block (BRAM + output register).
  localparam int GRAPHICS_PIPE_LAT = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic in_span(input cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Graphics read port and VGA pin bundle around the timing controller.
interface vga_timing_ctrl_if;
  import vga_timing_ctrl_pkg::*;

  logic [COLOR_W-1:0] i_r;
  logic [COLOR_W-1:0] i_g;
  logic [COLOR_W-1:0] i_b;
  cnt_t               o_x_read;
  cnt_t               o_y_read;
  logic               o_hs;
  logic               o_vs;
  logic [COLOR_W-1:0] o_r;
  logic [COLOR_W-1:0] o_g;
  logic [COLOR_W-1:0] o_b;
  logic               o_active;
  logic               o_frame_tick;

  modport master (
    input  i_r, i_g, i_b,
    output o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_active, o_frame_tick
  );

  modport slave (
    output i_r, i_g, i_b,
    input  o_x_read, o_y_read, o_hs, o_vs, o_r, o_g, o_b, o_active, o_frame_tick
  );

endinterface

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register; reset loads every stage with RST_VAL so nothing
// stale can emerge after reset release.
module sig_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator and pin output stage; sync/blank are delayed to
// line up with the colour coming back from graphics.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL,
  parameter int   PIPE_LAT = GRAPHICS_PIPE_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_ctrl_if.master  bus
);

  localparam int    H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int    V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t  H_MAX     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t  V_MAX     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t  V_TICK    = cnt_t'(V_ACTIVE);
  localparam sync_t SYNC_IDLE = '{act: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

  cnt_t                 h_cnt;
  cnt_t                 v_cnt;
  sync_t                sync_p0;
  sync_t                sync_dly;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 hs_q;
  logic                 vs_q;
  logic                 act_q;
  logic                 tick_q;

  // Stage 0: raster counters and combinational window decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  always_comb begin
    sync_p0     = SYNC_IDLE;
    sync_p0.act = in_span(h_cnt, 0, H_ACTIVE) && in_span(v_cnt, 0, V_ACTIVE);
    sync_p0.hs  = in_span(h_cnt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
    sync_p0.vs  = in_span(v_cnt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
  end

  // Stages 1..PIPE_LAT: match the graphics read latency
  sig_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sync_p0),
    .q     (sync_dly)
  );

  // Output register: colour gated by the aligned active flag, sync to pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      act_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      rgb_q  <= sync_dly.act ? {bus.i_r, bus.i_g, bus.i_b} : '0;
      hs_q   <= sync_dly.hs;
      vs_q   <= sync_dly.vs;
      act_q  <= sync_dly.act;
      // Game logic only needs blank timing, so the tick skips the colour pipeline.
      tick_q <= (h_cnt == '0) && (v_cnt == V_TICK);
    end
  end

  assign bus.o_x_read     = h_cnt;
  assign bus.o_y_read     = v_cnt;
  assign {bus.o_r, bus.o_g, bus.o_b} = rgb_q;
  assign bus.o_hs         = hs_q;
  assign bus.o_vs         = vs_q;
  assign bus.o_active     = act_q;
  assign bus.o_frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: full-size timing for line checks, a shrunken raster for
// whole-frame checks, and a PIPE_LAT=1 build for alignment.
module tb_vga_timing_ctrl;
  import vga_timing_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if bus_a ();
  vga_timing_ctrl_if bus_b ();
  vga_timing_ctrl_if bus_c ();

  vga_timing_ctrl #(.PIPE_LAT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_LAT(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_LAT(1)
  ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Graphics models: colour encodes the coordinates it was read for.
  logic [11:0] ga1;
  logic [11:0] gb1;
  always @(posedge clk) begin
    ga1 <= {bus_a.o_x_read[3:0], bus_a.o_y_read[3:0], 4'hA};
    {bus_a.i_r, bus_a.i_g, bus_a.i_b} <= ga1;
    gb1 <= {bus_b.o_x_read[3:0], bus_b.o_y_read[3:0], 4'hA};
    {bus_b.i_r, bus_b.i_g, bus_b.i_b} <= gb1;
    {bus_c.i_r, bus_c.i_g, bus_c.i_b} <= {bus_c.o_x_read[3:0], bus_c.o_y_read[3:0], 4'hA};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // k = clocks since reset release; pins show the counter value from k-lat-1.
  task automatic chk_pins(input string tag, input int k, input int lat,
                          input int ha, input int hfp, input int hsy, input int hbp,
                          input int va, input int vfp, input int vsy, input int vbp,
                          input cnt_t x, input cnt_t y, input logic act, input logic hs,
                          input logic vs, input logic [11:0] rgb, input logic tick);
    int ht, vt, kc, px, py;
    logic e_act, e_hs, e_vs, e_tick;
    logic [11:0] e_rgb;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    kc = k - lat - 1;
    chk({tag, " x_read"}, k, int'(x), k % ht);
    chk({tag, " y_read"}, k, int'(y), (k / ht) % vt);
    if (kc < 0) begin
      e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
    end else begin
      px    = kc % ht;
      py    = (kc / ht) % vt;
      e_act = (px < ha) && (py < va);
      e_hs  = !((px >= ha + hfp) && (px < ha + hfp + hsy));
      e_vs  = !((py >= va + vfp) && (py < va + vfp + vsy));
      e_rgb = e_act ? {px[3:0], py[3:0], 4'hA} : 12'h000;
    end
    e_tick = (k >= 1) && (((k - 1) % (ht * vt)) == va * ht);
    chk({tag, " active"}, k, int'(act), int'(e_act));
    chk({tag, " hs"}, k, int'(hs), int'(e_hs));
    chk({tag, " vs"}, k, int'(vs), int'(e_vs));
    chk({tag, " rgb"}, k, int'(rgb), int'(e_rgb));
    chk({tag, " tick"}, k, int'(tick), int'(e_tick));
  endtask

  task automatic sample_all(input int k);
    chk_pins("A", k, 2, 640, 16, 96, 48, 480, 10, 2, 33,
             bus_a.o_x_read, bus_a.o_y_read, bus_a.o_active, bus_a.o_hs, bus_a.o_vs,
             {bus_a.o_r, bus_a.o_g, bus_a.o_b}, bus_a.o_frame_tick);
    chk_pins("B", k, 2, 16, 2, 4, 3, 6, 1, 2, 1,
             bus_b.o_x_read, bus_b.o_y_read, bus_b.o_active, bus_b.o_hs, bus_b.o_vs,
             {bus_b.o_r, bus_b.o_g, bus_b.o_b}, bus_b.o_frame_tick);
    chk_pins("C", k, 1, 16, 2, 4, 3, 6, 1, 2, 1,
             bus_c.o_x_read, bus_c.o_y_read, bus_c.o_active, bus_c.o_hs, bus_c.o_vs,
             {bus_c.o_r, bus_c.o_g, bus_c.o_b}, bus_c.o_frame_tick);
  endtask

  initial begin
    int a_fall, a_low, b_vf1, b_vf2, b_vlow, b_t1, b_t2, b_ticks, c_vf1, c_t1;
    logic a_hs_prev, b_vs_prev, c_vs_prev, found;
    a_fall = -1; a_low = 0; b_vf1 = -1; b_vf2 = -1; b_vlow = 0;
    b_t1 = -1; b_t2 = -1; b_ticks = 0; c_vf1 = -1; c_t1 = -1;

    rst_n = 1'b0;
    repeat (5) step();
    sample_all(0);
    rst_n = 1'b1;
    sample_all(0);
    a_hs_prev = bus_a.o_hs; b_vs_prev = bus_b.o_vs; c_vs_prev = bus_c.o_vs;

    for (int k = 1; k <= 1700; k++) begin
      step();
      sample_all(k);
      if (k == 1)   chk("A x after release", k, int'(bus_a.o_x_read), 1);
      if (k == 2)   chk("A no pixel yet", k, int'(bus_a.o_active), 0);
      if (k == 3)   chk("A first pixel", k, int'({bus_a.o_r, bus_a.o_g, bus_a.o_b}), 12'h00A);
      if (k == 799) chk("A x max", k, int'(bus_a.o_x_read), 799);
      if (k == 800) chk("A x wrap", k, int'(bus_a.o_x_read), 0);
      if (k == 800) chk("A y incr", k, int'(bus_a.o_y_read), 1);
      if (k < 1000 && !bus_a.o_hs) a_low++;
      if (a_hs_prev && !bus_a.o_hs && a_fall < 0) a_fall = k;
      if (k < 250 && !bus_b.o_vs) b_vlow++;
      if (k < 520 && b_vs_prev && !bus_b.o_vs) begin
        if (b_vf1 < 0) b_vf1 = k; else if (b_vf2 < 0) b_vf2 = k;
      end
      if (k < 520 && bus_b.o_frame_tick) begin
        b_ticks++;
        if (b_t1 < 0) b_t1 = k; else if (b_t2 < 0) b_t2 = k;
      end
      if (c_vs_prev && !bus_c.o_vs && c_vf1 < 0) c_vf1 = k;
      if (bus_c.o_frame_tick && c_t1 < 0) c_t1 = k;
      a_hs_prev = bus_a.o_hs; b_vs_prev = bus_b.o_vs; c_vs_prev = bus_c.o_vs;
    end

    chk("A hs fall", 0, a_fall, 659);
    chk("A hs low width", 0, a_low, 96);
    chk("B vs fall", 0, b_vf1, 178);
    chk("B vs period", 0, b_vf2 - b_vf1, 250);
    chk("B vs low width", 0, b_vlow, 50);
    chk("B tick first", 0, b_t1, 151);
    chk("B tick period", 0, b_t2 - b_t1, 250);
    chk("B tick count", 0, b_ticks, 2);
    chk("C vs fall", 0, c_vf1, 177);
    chk("C tick first", 0, c_t1, 151);

    // Reset in the middle of an hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (bus_a.o_x_read == cnt_t'(700)) found = 1'b1;
    end
    chk("A reach h700", 0, int'(found), 1);
    chk("A hs low mid-sync", 0, int'(bus_a.o_hs), 0);
    rst_n = 1'b0;
    step();
    chk("A hs after reset", 0, int'(bus_a.o_hs), 1);
    sample_all(0);
    rst_n = 1'b1;
    a_low = 0;
    for (int k = 1; k <= 700; k++) begin
      step();
      sample_all(k);
      if (k < 659 && !bus_a.o_hs) a_low++;
    end
    chk("A no residual hs", 0, a_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
